// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - preset table, widths and state codes for the frequency step controller
package freq_pkg;

  localparam int IDX_W     = 3;
  localparam int DIV_W     = 11;
  localparam int FREQ_W    = 10;
  localparam int NUM_TABLE = 8;

  localparam logic [1:0] ST_HALT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  // Each divisor is the reload value; the tick period is divisor+1 cycles.
  localparam logic [DIV_W-1:0] DIV_TABLE [NUM_TABLE] = '{
    11'd1666, 11'd999, 11'd666, 11'd499, 11'd399, 11'd333, 11'd285, 11'd249
  };

  localparam logic [FREQ_W-1:0] FREQ_TABLE [NUM_TABLE] = '{
    10'd30, 10'd50, 10'd75, 10'd100, 10'd125, 10'd150, 10'd175, 10'd200
  };

endpackage

// File: rtl/freq_div_rom.sv
// rtl/freq_div_rom.sv - combinational preset index to divisor/frequency lookup
module freq_div_rom
  import freq_pkg::*;
(
  input  logic [IDX_W-1:0]  idx,
  output logic [DIV_W-1:0]  div,
  output logic [FREQ_W-1:0] freq
);

  always_comb begin
    div  = '0;
    freq = '0;
    if ({1'b0, idx} < (IDX_W+1)'(NUM_TABLE)) begin
      div  = DIV_TABLE[idx];
      freq = FREQ_TABLE[idx];
    end
  end

endmodule

// File: rtl/freq_step_controller.sv
// rtl/freq_step_controller.sv - preset-stepped tick divider; preset changes land only on period boundaries
module freq_step_controller
  import freq_pkg::*;
#(
  parameter int NUM_PRESETS = 8,
  parameter int RESET_IDX   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              step_up,
  input  logic              step_down,
  output logic              tick,
  output logic [DIV_W-1:0]  divisor,
  output logic [FREQ_W-1:0] freq_hz,
  output logic [IDX_W-1:0]  sel_idx,
  output logic              pending
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_PRESETS - 1);

  logic [1:0]        state, next_state;
  logic [DIV_W-1:0]  cnt;
  logic [IDX_W-1:0]  target, next_target, next_sel;
  logic [IDX_W-1:0]  base, step_idx;
  logic [DIV_W-1:0]  rom_div;
  logic [FREQ_W-1:0] rom_freq;
  logic              at_tc;

  // Looks up the preset that will be applied after this edge, so the
  // reload value and the registered outputs always agree.
  freq_div_rom u_rom (
    .idx  (next_sel),
    .div  (rom_div),
    .freq (rom_freq)
  );

  assign at_tc   = (cnt == '0);
  assign pending = (state == ST_PEND);

  always_comb begin
    base     = (state == ST_PEND) ? target : sel_idx;
    step_idx = base;
    if (step_up && !step_down && base != MAX_IDX)
      step_idx = base + 3'd1;
    else if (step_down && !step_up && base != '0)
      step_idx = base - 3'd1;

    next_state  = state;
    next_target = target;
    next_sel    = sel_idx;
    case (state)
      ST_HALT: begin
        next_sel    = step_idx;
        next_target = step_idx;
        if (en) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (!en) begin
          next_state = ST_HALT;
        end else if (step_idx != sel_idx) begin
          next_target = step_idx;
          next_state  = ST_PEND;
        end
      end
      ST_PEND: begin
        next_target = step_idx;
        if (!en) begin
          next_state = ST_HALT;
          next_sel   = step_idx;
        end else if (at_tc) begin
          next_state = ST_RUN;
          next_sel   = step_idx;
        end
      end
      default: next_state = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_HALT;
      cnt     <= DIV_TABLE[RESET_IDX];
      target  <= IDX_W'(RESET_IDX);
      sel_idx <= IDX_W'(RESET_IDX);
      divisor <= DIV_TABLE[RESET_IDX];
      freq_hz <= FREQ_TABLE[RESET_IDX];
      tick    <= 1'b0;
    end else begin
      state   <= next_state;
      target  <= next_target;
      sel_idx <= next_sel;
      divisor <= rom_div;
      freq_hz <= rom_freq;
      tick    <= 1'b0;
      if (state == ST_HALT) begin
        if (en) cnt <= rom_div;
      end else if (en) begin
        if (at_tc) begin
          cnt  <= rom_div;
          tick <= 1'b1;
        end else begin
          cnt <= cnt - 11'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_step_controller.sv
// tb/tb_freq_step_controller.sv - directed and randomized checks against a behavioural preset/period model
module tb_freq_step_controller;

  localparam int DIV_T [8] = '{1666, 999, 666, 499, 399, 333, 285, 249};
  localparam int FRQ_T [8] = '{30, 50, 75, 100, 125, 150, 175, 200};

  logic        clk = 1'b0;
  logic        reset, en, step_up, step_down;
  logic        tick;
  logic [10:0] divisor;
  logic [9:0]  freq_hz;
  logic [2:0]  sel_idx;
  logic        pending;

  int n_checks = 0;
  int n_errors = 0;

  bit m_run;
  int m_app, m_req, m_phase;
  bit m_tick;

  freq_step_controller #(.NUM_PRESETS(8), .RESET_IDX(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .step_up   (step_up),
    .step_down (step_down),
    .tick      (tick),
    .divisor   (divisor),
    .freq_hz   (freq_hz),
    .sel_idx   (sel_idx),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 7) ? 7 : v);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // m_req = -1 means no request outstanding; m_phase counts running edges since the last reload.
  task automatic model_step(input bit r, input bit e, input bit u, input bit d);
    int  dir, cand;
    bit  had;
    dir    = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
    m_tick = 1'b0;
    if (r) begin
      m_run = 1'b0; m_app = 3; m_req = -1; m_phase = 0;
    end else if (!m_run) begin
      m_app = clamp(m_app + dir);
      if (e) begin m_run = 1'b1; m_phase = 0; end
    end else if (!e) begin
      if (m_req >= 0) m_app = clamp(m_req + dir);
      m_req = -1;
      m_run = 1'b0;
    end else begin
      had  = (m_req >= 0);
      cand = clamp((had ? m_req : m_app) + dir);
      if (had || cand != m_app) m_req = cand;
      if (m_phase == DIV_T[m_app]) begin
        m_tick  = 1'b1;
        m_phase = 0;
        if (had) begin m_app = m_req; m_req = -1; end
      end else begin
        m_phase++;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit u, input bit d);
    @(negedge clk);
    reset = r; en = e; step_up = u; step_down = d;
    @(posedge clk);
    model_step(r, e, u, d);
    #1;
    check("tick", tick, m_tick);
    check("sel_idx", sel_idx, m_app);
    check("divisor", divisor, DIV_T[m_app]);
    check("freq_hz", freq_hz, FRQ_T[m_app]);
    check("pending", pending, (m_req >= 0) ? 1 : 0);
  endtask

  task automatic run_until_tick(input int budget, output int waited);
    waited = 0;
    do begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      waited++;
    end while (!tick && waited < budget);
    if (!tick) check("tick_timeout", 0, 1);
  endtask

  initial begin
    int w;
    bit e_cur, r, u, d;
    reset = 1'b1; en = 1'b0; step_up = 1'b0; step_down = 1'b0;

    // Reset values, with steps ignored while reset is high
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_sel", sel_idx, 3);
    check("rst_div", divisor, 499);
    check("rst_freq", freq_hz, 100);
    check("rst_pend", pending, 0);
    check("rst_tick", tick, 0);

    // First tick 500 cycles after the RUN-entry edge, then every 500
    run_until_tick(2000, w);
    check("first_tick_gap", w, 501);
    run_until_tick(2000, w);
    check("period_500", w, 500);

    // Step up one cycle after a tick: applies at the next terminal count
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("pend_after_up", pending, 1);
    check("div_before_apply", divisor, 499);
    run_until_tick(2000, w);
    check("apply_gap", w, 499);
    check("div_125", divisor, 399);
    check("freq_125", freq_hz, 125);
    run_until_tick(2000, w);
    check("period_400", w, 400);

    // Chained steps while pending: 4 -> target 6
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    run_until_tick(2000, w);
    check("div_175", divisor, 285);
    check("freq_175", freq_hz, 175);
    run_until_tick(2000, w);
    check("period_286", w, 286);

    // Down then up while pending returns to the applied preset: no-op apply
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("noop_pend", pending, 1);
    run_until_tick(2000, w);
    check("noop_gap", w, 284);
    check("noop_div", divisor, 285);
    run_until_tick(2000, w);
    check("noop_period", w, 286);

    // Target 2 pending, then en drops: applied on halt, resume reloads 666
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("halt_div", divisor, 666);
    check("halt_tick", tick, 0);
    check("halt_pend", pending, 0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run_until_tick(2000, w);
    check("resume_gap", w, 668);

    // Reset mid-pend at index 5 with target 6
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    run_until_tick(2000, w);
    check("idx5", sel_idx, 5);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("midpend_rst_sel", sel_idx, 3);
    check("midpend_rst_div", divisor, 499);
    check("midpend_rst_pend", pending, 0);
    check("midpend_rst_tick", tick, 0);

    // Saturation at both ends and simultaneous steps, in HALT and RUN
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("sat_hi", sel_idx, 7);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("sat_hi_run_pend", pending, 0);
    check("sat_hi_run_sel", sel_idx, 7);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("sat_lo", sel_idx, 0);
    check("sat_lo_freq", freq_hz, 30);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check("both_sel", sel_idx, 3);
    check("both_pend", pending, 0);

    // Randomized traffic checked cycle by cycle against the model
    e_cur = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(299) == 0) e_cur = !e_cur;
      r = ($urandom_range(1999) == 0);
      u = ($urandom_range(29) == 0);
      d = ($urandom_range(29) == 0);
      cycle(r, e_cur, u, d);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
